// File: rtl/alt_vipvfr120_common_avalon_mm_burst_slave.sv
// -----------------------------------------------------------------------------
// alt_vipvfr120_common_avalon_mm_burst_slave
//
// Avalon-MM burst-capable slave fronting an internal word-addressed memory.
// Accepts write and read bursts, returns pipelined read data flagged by
// av_readdatavalid and applies av_waitrequest backpressure.
//
// Optional feature macro: VIPVFR_MM_SLAVE_BACKPRESSURE_EN
//   When defined, a 16-bit Fibonacci LFSR (taps 16/14/13/11, seed 16'hACE1)
//   inserts pseudo-random waitrequest cycles in IDLE and WRITE_BURST.
//
// Parameters:
//   ADDR_WIDTH     word address width
//   DATA_WIDTH     data word width
//   BURST_WIDTH    av_burstcount width
//   MEM_DEPTH_LOG2 memory holds 2^MEM_DEPTH_LOG2 words
//
// Ports:
//   clock            in   rising-edge clock
//   reset            in   asynchronous, active-low reset
//   av_address       in   word address, sampled on the first beat only
//   av_burstcount    in   beats in the burst, sampled with the command
//   av_writedata     in   write beat data
//   av_write         in   write beat request
//   av_read          in   read burst command
//   av_readdata      out  read beat data (holds when not valid)
//   av_readdatavalid out  av_readdata valid this cycle
//   av_waitrequest   out  slave not accepting; master must hold the request
//   protocol_error   out  sticky flag for illegal master behaviour
// -----------------------------------------------------------------------------
module alt_vipvfr120_common_avalon_mm_burst_slave #(
    parameter int ADDR_WIDTH     = 16,
    parameter int DATA_WIDTH     = 16,
    parameter int BURST_WIDTH    = 6,
    parameter int MEM_DEPTH_LOG2 = 8
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [ADDR_WIDTH-1:0]  av_address,
    input  logic [BURST_WIDTH-1:0] av_burstcount,
    input  logic [DATA_WIDTH-1:0]  av_writedata,
    input  logic                   av_write,
    input  logic                   av_read,
    output logic [DATA_WIDTH-1:0]  av_readdata,
    output logic                   av_readdatavalid,
    output logic                   av_waitrequest,
    output logic                   protocol_error
);

    localparam int MEM_DEPTH = 1 << MEM_DEPTH_LOG2;

    typedef enum logic [1:0] {
        IDLE,
        WRITE_BURST,
        READ_BURST
    } state_t;

    state_t                    state;
    logic [MEM_DEPTH_LOG2-1:0] burst_addr;
    logic [BURST_WIDTH-1:0]    remaining;
    logic [DATA_WIDTH-1:0]     mem [MEM_DEPTH];

    logic [MEM_DEPTH_LOG2-1:0] cmd_addr;
    logic [BURST_WIDTH-1:0]    cmd_count;
    logic                      cmd_count_zero;
    logic                      wr_accept;
    logic                      rd_accept;
    logic [MEM_DEPTH_LOG2-1:0] mem_waddr;
    logic                      hold_next;

    // Upper address bits are intentionally ignored.
    logic unused_addr;
    assign unused_addr = ^av_address;

    always_comb begin
        cmd_addr       = av_address[MEM_DEPTH_LOG2-1:0];
        cmd_count_zero = (av_burstcount == '0);
        cmd_count      = cmd_count_zero ? BURST_WIDTH'(1) : av_burstcount;
        wr_accept      = av_write && !av_waitrequest && (state != READ_BURST);
        // A write takes priority over a simultaneous read in IDLE.
        rd_accept      = av_read && !av_write && !av_waitrequest && (state == IDLE);
        mem_waddr      = (state == IDLE) ? cmd_addr : burst_addr;
    end

`ifdef VIPVFR_MM_SLAVE_BACKPRESSURE_EN
    logic [15:0] lfsr;
    logic [15:0] lfsr_next;

    assign lfsr_next = {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            lfsr <= 16'hACE1;
        end else begin
            lfsr <= lfsr_next;
        end
    end

    // waitrequest is registered, so it follows bit 0 of the LFSR value
    // that will be current during the coming cycle.
    assign hold_next = lfsr_next[0];
`else
    assign hold_next = 1'b0;
`endif

    // Memory contents are deliberately not reset.
    always_ff @(posedge clock) begin
        if (wr_accept) begin
            mem[mem_waddr] <= av_writedata;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state            <= IDLE;
            burst_addr       <= '0;
            remaining        <= '0;
            av_waitrequest   <= 1'b1;
            av_readdatavalid <= 1'b0;
            av_readdata      <= '0;
            protocol_error   <= 1'b0;
        end else begin
            av_readdatavalid <= 1'b0;
            case (state)
                IDLE: begin
                    av_waitrequest <= hold_next;
                    if (wr_accept) begin
                        burst_addr <= cmd_addr + MEM_DEPTH_LOG2'(1);
                        remaining  <= cmd_count - BURST_WIDTH'(1);
                        if (cmd_count != BURST_WIDTH'(1)) begin
                            state <= WRITE_BURST;
                        end
                        if (cmd_count_zero || av_read) begin
                            protocol_error <= 1'b1;
                        end
                    end else if (rd_accept) begin
                        burst_addr     <= cmd_addr;
                        remaining      <= cmd_count;
                        state          <= READ_BURST;
                        av_waitrequest <= 1'b1;
                        if (cmd_count_zero) begin
                            protocol_error <= 1'b1;
                        end
                    end
                end

                WRITE_BURST: begin
                    av_waitrequest <= hold_next;
                    if (av_read) begin
                        protocol_error <= 1'b1;
                    end
                    if (wr_accept) begin
                        burst_addr <= burst_addr + MEM_DEPTH_LOG2'(1);
                        remaining  <= remaining - BURST_WIDTH'(1);
                        if (remaining == BURST_WIDTH'(1)) begin
                            state <= IDLE;
                        end
                    end
                end

                READ_BURST: begin
                    // N issue cycles followed by one drain cycle while the
                    // last beat is on the bus; waitrequest stays high for all.
                    if (remaining != '0) begin
                        av_readdata      <= mem[burst_addr];
                        av_readdatavalid <= 1'b1;
                        burst_addr       <= burst_addr + MEM_DEPTH_LOG2'(1);
                        remaining        <= remaining - BURST_WIDTH'(1);
                        av_waitrequest   <= 1'b1;
                    end else begin
                        state          <= IDLE;
                        av_waitrequest <= hold_next;
                    end
                end

                default: begin
                    state          <= IDLE;
                    av_waitrequest <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alt_vipvfr120_common_avalon_mm_burst_slave.sv
// -----------------------------------------------------------------------------
// tb_alt_vipvfr120_common_avalon_mm_burst_slave
//
// Self-checking bench: directed tests followed by randomized bursts, checked
// every cycle against a memory-array / expected-beat-queue reference model.
// -----------------------------------------------------------------------------
module tb_alt_vipvfr120_common_avalon_mm_burst_slave;

    logic        clock;
    logic        reset;
    logic [15:0] av_address;
    logic [5:0]  av_burstcount;
    logic [15:0] av_writedata;
    logic        av_write;
    logic        av_read;
    logic [15:0] av_readdata;
    logic        av_readdatavalid;
    logic        av_waitrequest;
    logic        protocol_error;

    alt_vipvfr120_common_avalon_mm_burst_slave #(
        .ADDR_WIDTH     (16),
        .DATA_WIDTH     (16),
        .BURST_WIDTH    (6),
        .MEM_DEPTH_LOG2 (8)
    ) dut (
        .clock            (clock),
        .reset            (reset),
        .av_address       (av_address),
        .av_burstcount    (av_burstcount),
        .av_writedata     (av_writedata),
        .av_write         (av_write),
        .av_read          (av_read),
        .av_readdata      (av_readdata),
        .av_readdatavalid (av_readdatavalid),
        .av_waitrequest   (av_waitrequest),
        .protocol_error   (protocol_error)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int unsigned cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    // Reference model state
    typedef struct {
        int unsigned cyc;
        logic [15:0] data;
    } beat_t;

    logic [15:0] model_mem [256];
    beat_t       exp_q [$];
    int unsigned busy_lo = 1;
    int unsigned busy_hi = 0;
    logic        perr_exp = 1'b0;
    logic [15:0] last_data = 16'h0;
    bit          mon_en = 1'b0;
    int unsigned last_t = 0;

    int errors = 0;
    int checks = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Per-cycle monitor: read beats, data hold, waitrequest, error flag.
    always @(negedge clock) begin
        if (mon_en) begin
            if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
                check_eq("rdvalid_beat", 32'(av_readdatavalid), 32'd1);
                check_eq("rddata", 32'(av_readdata), 32'(exp_q[0].data));
                last_data = exp_q[0].data;
                void'(exp_q.pop_front());
            end else begin
                check_eq("rdvalid_idle", 32'(av_readdatavalid), 32'd0);
                check_eq("rddata_hold", 32'(av_readdata), 32'(last_data));
            end
            if (cyc >= busy_lo && cyc <= busy_hi) begin
                check_eq("wait_read", 32'(av_waitrequest), 32'd1);
            end else begin
`ifndef VIPVFR_MM_SLAVE_BACKPRESSURE_EN
                check_eq("wait_free", 32'(av_waitrequest), 32'd0);
`endif
            end
            check_eq("perr", 32'(protocol_error), 32'(perr_exp));
        end
    end

    // Hold the current request until the slave takes it; returns the cycle
    // in which it was accepted. Called at #1 after a rising edge.
    task automatic wait_accept(output int unsigned t);
        bit          acc;
        bit          done;
        int unsigned guard;
        done  = 1'b0;
        guard = 0;
        t     = cyc;
        while (!done) begin
            acc = (av_waitrequest == 1'b0);
            t   = cyc;
            @(posedge clock);
            #1;
            if (acc) begin
                done = 1'b1;
            end else begin
                guard++;
                if (guard > 500) begin
                    check_eq("accept_timeout", 32'd1, 32'd0);
                    done = 1'b1;
                end
            end
        end
    endtask

    task automatic idle_cycles(input int unsigned n);
        for (int unsigned i = 0; i < n; i++) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic wr_burst(input logic [15:0] addr, input int unsigned n_field,
                            input logic [15:0] base, input bit rand_data,
                            input int unsigned gap_max, input bit inject_read,
                            input bit with_read);
        int unsigned n_eff;
        int unsigned t;
        int unsigned gaps;
        logic [15:0] d;
        logic [7:0]  idx;
        n_eff = (n_field == 0) ? 1 : n_field;
        for (int unsigned k = 0; k < n_eff; k++) begin
            d = rand_data ? 16'($urandom) : base + 16'(k);
            av_write     = 1'b1;
            av_writedata = d;
            if (k == 0) begin
                av_address    = addr;
                av_burstcount = n_field[5:0];
                av_read       = with_read;
            end else begin
                av_address    = 16'($urandom);
                av_burstcount = 6'($urandom);
            end
            wait_accept(t);
            idx            = addr[7:0] + 8'(k);
            model_mem[idx] = d;
            if (k == 0 && (n_field == 0 || with_read)) perr_exp = 1'b1;
            av_write   = 1'b0;
            av_read    = 1'b0;
            av_address = 16'($urandom);
            if (k + 1 < n_eff) begin
                gaps = $urandom_range(gap_max, 0);
                if (inject_read && k == 0 && gaps == 0) gaps = 1;
                for (int unsigned g = 0; g < gaps; g++) begin
                    if (inject_read && k == 0 && g == 0) av_read = 1'b1;
                    @(posedge clock);
                    #1;
                    if (av_read) begin
                        av_read  = 1'b0;
                        perr_exp = 1'b1;
                    end
                end
            end
        end
    endtask

    task automatic rd_burst(input logic [15:0] addr, input int unsigned n_field);
        int unsigned n_eff;
        int unsigned t;
        beat_t       b;
        logic [7:0]  idx;
        n_eff         = (n_field == 0) ? 1 : n_field;
        av_read       = 1'b1;
        av_address    = addr;
        av_burstcount = n_field[5:0];
        wait_accept(t);
        av_read       = 1'b0;
        av_address    = 16'($urandom);
        av_burstcount = 6'($urandom);
        for (int unsigned k = 0; k < n_eff; k++) begin
            idx    = addr[7:0] + 8'(k);
            b.cyc  = t + 2 + k;
            b.data = model_mem[idx];
            exp_q.push_back(b);
        end
        busy_lo = t + 1;
        busy_hi = t + n_eff + 1;
        if (n_field == 0) perr_exp = 1'b1;
        last_t = t;
    endtask

    // Called at #1 after a rising edge; asserts reset at once.
    task automatic do_reset();
        mon_en = 1'b0;
        reset  = 1'b0;
        #1;
        check_eq("rst_wait", 32'(av_waitrequest), 32'd1);
        check_eq("rst_valid", 32'(av_readdatavalid), 32'd0);
        check_eq("rst_data", 32'(av_readdata), 32'd0);
        check_eq("rst_perr", 32'(protocol_error), 32'd0);
        @(posedge clock);
        @(posedge clock);
        #1;
        reset = 1'b1;
        exp_q.delete();
        busy_lo   = 1;
        busy_hi   = 0;
        perr_exp  = 1'b0;
        last_data = 16'h0;
        @(posedge clock);
        #1;
`ifndef VIPVFR_MM_SLAVE_BACKPRESSURE_EN
        check_eq("post_rst_wait", 32'(av_waitrequest), 32'd0);
`endif
        check_eq("post_rst_valid", 32'(av_readdatavalid), 32'd0);
        mon_en = 1'b1;
    endtask

    initial begin : watchdog
        #5ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        logic [15:0] ra;
        int unsigned rn;
        reset         = 1'b1;
        av_address    = '0;
        av_burstcount = '0;
        av_writedata  = '0;
        av_write      = 1'b0;
        av_read       = 1'b0;
        #2;
        do_reset();

        // Fill the whole memory so every later read has defined contents.
        for (int unsigned b = 0; b < 8; b++) begin
            wr_burst(16'(b * 32), 32, 16'h0, 1'b1, 0, 1'b0, 1'b0);
        end
        idle_cycles(2);

        // Basic write then read at 0x0010.
        wr_burst(16'h0010, 4, 16'hA000, 1'b0, 0, 1'b0, 1'b0);
        idle_cycles(1);
        rd_burst(16'h0010, 4);
        idle_cycles(8);

        // Address wrap at the top of memory; upper address bits ignored.
        wr_burst(16'h00FE, 4, 16'hB000, 1'b0, 0, 1'b0, 1'b0);
        rd_burst(16'h0000, 2);
        rd_burst(16'h73FE, 4);
        idle_cycles(3);

        // Write burst with 3-cycle gaps between beats.
        wr_burst(16'h0040, 5, 16'hC000, 1'b0, 3, 1'b0, 1'b0);
        wr_burst(16'h0080, 5, 16'hC100, 1'b0, 3, 1'b0, 1'b0);
        rd_burst(16'h0040, 5);
        rd_burst(16'h0080, 5);
        idle_cycles(8);

        // Randomized bursts.
        for (int unsigned i = 0; i < 1000; i++) begin
            ra = 16'($urandom);
            rn = ($urandom_range(7, 0) == 0) ? $urandom_range(63, 1) : $urandom_range(8, 1);
            idle_cycles($urandom_range(2, 0));
            if ($urandom_range(1, 0) == 1) begin
                wr_burst(ra, rn, 16'h0, 1'b1, 2, 1'b0, 1'b0);
            end else begin
                rd_burst(ra, rn);
            end
        end
        idle_cycles(70);

        // Reset in the middle of an 8-beat read.
        rd_burst(16'h0020, 8);
        while (cyc < last_t + 3) begin
            @(posedge clock);
            #1;
        end
        do_reset();
        idle_cycles(12);
        rd_burst(16'h0010, 4);
        idle_cycles(8);

        // Simultaneous read and write in IDLE.
        wr_burst(16'h0030, 1, 16'hD000, 1'b0, 0, 1'b0, 1'b1);
        idle_cycles(6);
        rd_burst(16'h0030, 1);
        idle_cycles(5);
        do_reset();
        idle_cycles(2);

        // Burst count of zero on a write, then on a read.
        wr_burst(16'h0031, 0, 16'hD100, 1'b0, 0, 1'b0, 1'b0);
        idle_cycles(4);
        do_reset();
        rd_burst(16'h0031, 0);
        idle_cycles(6);
        do_reset();
        idle_cycles(2);

        // Read asserted during a write burst.
        wr_burst(16'h0050, 3, 16'hE000, 1'b0, 2, 1'b1, 1'b0);
        rd_burst(16'h0050, 3);
        idle_cycles(8);

        mon_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/alt_vipvfr120_common_avalon_mm_burst_slave.md
# alt_vipvfr120_common_avalon_mm_burst_slave

Avalon-MM burst-capable slave (responder) fronting an internal word-addressed memory. It is the far end for the VIP common bursting master: it accepts write and read bursts, returns pipelined read data with `av_readdatavalid`, and applies `av_waitrequest` backpressure. It is used as the memory model in frame-reader/writer benches and as a small on-chip buffer in the SOPC.

## Interface
- `ADDR_WIDTH`, 16: word address width.
- `DATA_WIDTH`, 16: data word width.
- `BURST_WIDTH`, 6: `av_burstcount` width.
- `MEM_DEPTH_LOG2`, 8: memory holds 2^MEM_DEPTH_LOG2 words.

Ports:
- `clock`  in  1: single clock; all logic on the rising edge.
- `reset`  in  1: asynchronous, active-low reset (asserted when 0).
- `av_address`  in  ADDR_WIDTH: word address, sampled on the first beat only.
- `av_burstcount`  in  BURST_WIDTH: beats in the burst, sampled with the command.
- `av_writedata`  in  DATA_WIDTH: write beat data.
- `av_write`  in  1: write beat request.
- `av_read`  in  1: read burst command.
- `av_readdata`  out  DATA_WIDTH: read beat data.
- `av_readdatavalid`  out  1: `av_readdata` valid this cycle.
- `av_waitrequest`  out  1: slave not accepting; master must hold the request.
- `protocol_error`  out  1: sticky flag for illegal master behaviour.

## Operation
- Memory index is `addr[MEM_DEPTH_LOG2-1:0]`. Upper address bits are ignored. The burst address increments by 1 per beat and wraps modulo 2^MEM_DEPTH_LOG2.
- A request is accepted only in a cycle where it is asserted and `av_waitrequest`=0.
- FSM states: IDLE, WRITE_BURST, READ_BURST.
- **IDLE, write accepted:**
  - Latch the address and the count N.
  - Write beat 0 to the latched address.
  - If N=1, stay in IDLE; otherwise go to WRITE_BURST with a remaining count of N-1.
- **WRITE_BURST:**
  - Each accepted `av_write` writes to the next address and decrements the remaining count.
  - The last beat returns the FSM to IDLE.
  - The master may idle between beats; the slave waits indefinitely.
- **IDLE, read accepted:**
  - Latch the address and N, then go to READ_BURST.
  - Issue one memory read per cycle for N cycles.
  - Return to IDLE after the last `av_readdatavalid`.
- **Simultaneous `av_read` and `av_write` in IDLE:** the write is taken, the read is ignored, and `protocol_error` is set.
- **`av_read` asserted in WRITE_BURST:** ignored; `protocol_error` is set.
- **`av_burstcount`=0:** treated as 1; `protocol_error` is set.
- `protocol_error` clears only on reset.
- Memory contents are not reset. Reads return data from writes completed in earlier cycles.
- **Reset mid-burst:** the FSM returns to IDLE immediately and outstanding read beats are discarded.

## Timing
- Reset values:
  - `av_waitrequest`=1
  - `av_readdatavalid`=0
  - `av_readdata`=0
  - `protocol_error`=0
- After reset is released, `av_waitrequest` falls at the first rising edge.
- Write: zero wait states per beat. The memory is updated at the edge that accepts the beat.
- Read accepted at cycle T with count N:
  - beat k (0..N-1) is presented at cycle T+2+k, with `av_readdatavalid`=1;
  - `av_readdatavalid` is contiguous for the whole burst and is never backpressured.
- `av_waitrequest`=1 in READ_BURST, i.e. cycles T+1..T+N+1. The next command can be accepted at T+N+2 at the earliest.
- `av_readdata` holds its last value when `av_readdatavalid`=0.
- All outputs are registered.

## Configuration
- `VIPVFR_MM_SLAVE_BACKPRESSURE_EN` defined:
  - adds a 16-bit Fibonacci LFSR, taps 16/14/13/11, reset seed 16'hACE1, advancing every cycle;
  - in IDLE and WRITE_BURST, LFSR bit 0 = 1 forces `av_waitrequest`=1 for that cycle, so no command or write beat is accepted;
  - read data timing after acceptance is unchanged.
- Not defined: no LFSR is present, and `av_waitrequest` is high only during reset and READ_BURST.

## Test plan
- Write burst at address 0x0010, N=4, data 0xA000..0xA003 -> no waitrequest. Read burst at 0x0010, N=4, accepted at T -> `av_readdatavalid` at T+2..T+5 with 0xA000..0xA003.
- Write burst at 0x00FE, N=4 (MEM_DEPTH_LOG2=8) -> words land at 0xFE, 0xFF, 0x00, 0x01. A read of 0x00 with N=2 returns beats 2 and 3.
- Write burst with 3-cycle gaps between beats -> all beats are written, the FSM stays in WRITE_BURST until beat N, and `protocol_error`=0.
- `av_read` and `av_write` together in IDLE -> the write completes, no `av_readdatavalid` appears, and `protocol_error`=1 and stays set. `av_burstcount`=0 -> single beat, with the error flag set.
- Reset pulled low at T+3 of an N=8 read -> outputs return to their reset values asynchronously. After release: `av_waitrequest`=0 at the first edge and no stale `av_readdatavalid`.
- With `VIPVFR_MM_SLAVE_BACKPRESSURE_EN`, 1000 random bursts checked against a scoreboard -> all data matches, and no beat is accepted while `av_waitrequest`=1.
